out_interlace_ctrl: RTL and testbench

OUT_INTERLACE_CTRL -- requirements
Module: out_interlace_ctrl

---
 rtl/out_interlace_ctrl.sv | 122 ++++++++++++
 tb/tb_out_interlace_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/out_interlace_ctrl.sv
// rtl/out_interlace_ctrl.sv - two-branch bit FIFOs interlaced onto one serial X,Y,X,Y output
module out_interlace_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_100,
   input  logic             reset_N,
   input  logic             en,
   input  logic             x_in,
   input  logic             x_valid,
   output logic             x_ready,
   input  logic             y_in,
   input  logic             y_valid,
   output logic             y_ready,
   output logic             z,
   output logic             z_valid,
   output logic             z_is_x,
   output logic [CNT_W-1:0] pair_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y} state_t;

   state_t           state_q;
   logic [DEPTH-1:0] x_mem_q, y_mem_q;
   logic [AW-1:0]    x_wr_q, x_rd_q, y_wr_q, y_rd_q;
   logic [OW-1:0]    x_cnt_q, y_cnt_q, x_cnt_d, y_cnt_d;
   logic             z_q, z_valid_q, z_is_x_q;
   logic [CNT_W-1:0] pair_cnt_q;

   logic x_push, y_push, x_pop, y_pop, start_pair;
   logic x_head, y_head;

   assign x_ready = (x_cnt_q < OW'(DEPTH));
   assign y_ready = (y_cnt_q < OW'(DEPTH));
   assign x_push  = x_valid & x_ready;
   assign y_push  = y_valid & y_ready;
   assign x_head  = x_mem_q[x_rd_q];
   assign y_head  = y_mem_q[y_rd_q];

   // A pair only starts when both halves are already buffered, so SEND_X never lacks its Y.
   assign start_pair = en && (x_cnt_q != '0) && (y_cnt_q != '0)
                       && (state_q == IDLE || state_q == SEND_Y);
   assign x_pop = start_pair;
   assign y_pop = (state_q == SEND_X);

   always_comb begin
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      case ({x_push, x_pop})
         2'b10:   x_cnt_d = x_cnt_q + OW'(1);
         2'b01:   x_cnt_d = x_cnt_q - OW'(1);
         default: x_cnt_d = x_cnt_q;
      endcase
      case ({y_push, y_pop})
         2'b10:   y_cnt_d = y_cnt_q + OW'(1);
         2'b01:   y_cnt_d = y_cnt_q - OW'(1);
         default: y_cnt_d = y_cnt_q;
      endcase
   end

   always_ff @(posedge clk_100) begin
      if (x_push) x_mem_q[x_wr_q] <= x_in;
      if (y_push) y_mem_q[y_wr_q] <= y_in;
   end

   always_ff @(posedge clk_100 or negedge reset_N) begin
      if (!reset_N) begin
         state_q    <= IDLE;
         x_wr_q     <= '0;
         x_rd_q     <= '0;
         y_wr_q     <= '0;
         y_rd_q     <= '0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         z_q        <= 1'b0;
         z_valid_q  <= 1'b0;
         z_is_x_q   <= 1'b0;
         pair_cnt_q <= '0;
      end else begin
         if (x_push) x_wr_q <= x_wr_q + AW'(1);
         if (y_push) y_wr_q <= y_wr_q + AW'(1);
         if (x_pop)  x_rd_q <= x_rd_q + AW'(1);
         if (y_pop)  y_rd_q <= y_rd_q + AW'(1);
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;

         case (state_q)
            SEND_X: begin
               state_q    <= SEND_Y;
               z_q        <= y_head;
               z_valid_q  <= 1'b1;
               z_is_x_q   <= 1'b0;
               pair_cnt_q <= pair_cnt_q + CNT_W'(1);
            end
            IDLE, SEND_Y: begin
               if (start_pair) begin
                  state_q   <= SEND_X;
                  z_q       <= x_head;
                  z_valid_q <= 1'b1;
                  z_is_x_q  <= 1'b1;
               end else begin
                  state_q   <= IDLE;
                  z_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               z_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign z        = z_q;
   assign z_valid  = z_valid_q;
   assign z_is_x   = z_is_x_q;
   assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_out_interlace_ctrl.sv
// tb/tb_out_interlace_ctrl.sv - vector table, directed corners and random run against a queue model
module tb_out_interlace_ctrl;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int MASK  = (1 << CNT_W) - 1;

   logic             clk_100 = 1'b0;
   logic             reset_N;
   logic             en, x_in, x_valid, y_in, y_valid;
   logic             x_ready, y_ready, z, z_valid, z_is_x;
   logic [CNT_W-1:0] pair_cnt;

   int checks = 0;
   int errors = 0;

   bit xq[$];
   bit yq[$];
   bit m_pend, m_z, m_zv, m_zx;
   int m_cnt;

   out_interlace_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_100 (clk_100),
      .reset_N (reset_N),
      .en      (en),
      .x_in    (x_in),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .y_in    (y_in),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .z       (z),
      .z_valid (z_valid),
      .z_is_x  (z_is_x),
      .pair_cnt(pair_cnt)
   );

   always #5 clk_100 = ~clk_100;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      xq.delete();
      yq.delete();
      m_pend = 0;
      m_z    = 0;
      m_zv   = 0;
      m_zx   = 0;
      m_cnt  = 0;
   endtask

   // One clock: drive, check ready against model occupancy, advance model, check outputs.
   task automatic cycle(input bit xv, input bit xi, input bit yv, input bit yi, input bit e);
      bit xp, yp;
      x_valid = xv; x_in = xi; y_valid = yv; y_in = yi; en = e;
      check("x_ready", int'(x_ready), int'(xq.size() < DEPTH));
      check("y_ready", int'(y_ready), int'(yq.size() < DEPTH));
      xp = xv && (xq.size() < DEPTH);
      yp = yv && (yq.size() < DEPTH);
      @(posedge clk_100);
      if (m_pend) begin
         m_z = yq.pop_front(); m_zv = 1; m_zx = 0; m_pend = 0;
         m_cnt = (m_cnt + 1) & MASK;
      end else if (e && xq.size() > 0 && yq.size() > 0) begin
         m_z = xq.pop_front(); m_zv = 1; m_zx = 1; m_pend = 1;
      end else begin
         m_zv = 0;
      end
      if (xp) xq.push_back(xi);
      if (yp) yq.push_back(yi);
      #1;
      check("z", int'(z), int'(m_z));
      check("z_valid", int'(z_valid), int'(m_zv));
      if (m_zv) check("z_is_x", int'(z_is_x), int'(m_zx));
      check("pair_cnt", int'(pair_cnt), m_cnt);
   endtask

   typedef struct {
      bit xv, xi, yv, yi, e;
      bit ez, ezv, ezx;
      int ecnt;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [CNT_W-1:0] prev;
      bit done;

      // single pair, then a four-pair stream from idle
      tbl[0]  = '{1,1,1,0,1, 0,0,0, 0};
      tbl[1]  = '{0,0,0,0,1, 1,1,1, 0};
      tbl[2]  = '{0,0,0,0,1, 0,1,0, 1};
      tbl[3]  = '{0,0,0,0,1, 0,0,0, 1};
      tbl[4]  = '{1,1,1,0,1, 0,0,0, 1};
      tbl[5]  = '{1,1,1,1,1, 1,1,1, 1};
      tbl[6]  = '{1,0,1,1,1, 0,1,0, 2};
      tbl[7]  = '{1,1,1,1,1, 1,1,1, 2};
      tbl[8]  = '{0,0,0,0,1, 1,1,0, 3};
      tbl[9]  = '{0,0,0,0,1, 0,1,1, 3};
      tbl[10] = '{0,0,0,0,1, 1,1,0, 4};
      tbl[11] = '{0,0,0,0,1, 1,1,1, 4};
      tbl[12] = '{0,0,0,0,1, 1,1,0, 5};
      tbl[13] = '{0,0,0,0,1, 1,0,0, 5};

      reset_N = 0; en = 0; x_in = 0; x_valid = 1; y_in = 0; y_valid = 1;
      model_clear();
      repeat (2) @(posedge clk_100);
      #1;
      check("rst_z", int'(z), 0);
      check("rst_z_valid", int'(z_valid), 0);
      check("rst_z_is_x", int'(z_is_x), 0);
      check("rst_pair_cnt", int'(pair_cnt), 0);
      check("rst_x_ready", int'(x_ready), 1);
      check("rst_y_ready", int'(y_ready), 1);
      x_valid = 0; y_valid = 0;
      reset_N = 1;

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].xv, tbl[i].xi, tbl[i].yv, tbl[i].yi, tbl[i].e);
         check($sformatf("tbl%0d_z", i), int'(z), int'(tbl[i].ez));
         check($sformatf("tbl%0d_z_valid", i), int'(z_valid), int'(tbl[i].ezv));
         if (tbl[i].ezv) check($sformatf("tbl%0d_z_is_x", i), int'(z_is_x), int'(tbl[i].ezx));
         check($sformatf("tbl%0d_pair_cnt", i), int'(pair_cnt), tbl[i].ecnt);
      end

      // X FIFO fills with no Y partner
      for (int i = 0; i < 4; i++) cycle(1, i[0], 0, 0, 1);
      check("xfull_ready", int'(x_ready), 0);
      check("xfull_no_out", int'(z_valid), 0);
      cycle(1, 1, 0, 0, 1);
      check("xfull_still_not_ready", int'(x_ready), 0);
      cycle(0, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 1);
      check("xfull_pair_x", int'(z_valid & z_is_x), 1);
      check("xfull_ready_back", int'(x_ready), 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, i[0], 1);
      repeat (8) cycle(0, 0, 0, 0, 1);

      // en dropped right after SEND_X is entered
      cycle(1, 1, 1, 0, 0);
      cycle(1, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1);
      check("endrop_x", int'(z_valid & z_is_x), 1);
      cycle(0, 0, 0, 0, 0);
      check("endrop_y_valid", int'(z_valid), 1);
      check("endrop_y_is_y", int'(z_is_x), 0);
      repeat (3) begin
         cycle(0, 0, 0, 0, 0);
         check("endrop_held", int'(z_valid), 0);
      end
      repeat (3) cycle(0, 0, 0, 0, 1);

      // reset while in SEND_X with two entries left per branch
      cycle(1, 1, 1, 0, 0);
      cycle(1, 0, 1, 1, 0);
      cycle(1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("midrst_in_send_x", int'(z_valid & z_is_x), 1);
      reset_N = 0; x_valid = 1; y_valid = 1; x_in = 1; y_in = 1;
      #2;
      check("midrst_z_valid", int'(z_valid), 0);
      check("midrst_z", int'(z), 0);
      check("midrst_pair_cnt", int'(pair_cnt), 0);
      @(posedge clk_100);
      #1;
      check("midrst_x_ready", int'(x_ready), 1);
      check("midrst_y_ready", int'(y_ready), 1);
      check("midrst_z_is_x", int'(z_is_x), 0);
      x_valid = 0; y_valid = 0;
      reset_N = 1;
      model_clear();
      cycle(1, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 1);
      check("postrst_first_x", int'(z_is_x), 1);
      check("postrst_first_z", int'(z), 0);
      cycle(0, 0, 0, 0, 1);
      check("postrst_y_z", int'(z), 1);
      cycle(0, 0, 0, 0, 1);

      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
               1'($urandom), $urandom_range(0, 7) != 0);

      done = 0;
      prev = pair_cnt;
      for (int i = 0; i < 1200 && !done; i++) begin
         prev = pair_cnt;
         cycle(1, 1'($urandom), 1, 1'($urandom), 1);
         if (prev == CNT_W'(MASK) && m_cnt == 0) done = 1;
      end
      if (done) begin
         check("wrap_before", int'(prev), MASK);
         check("wrap_after", int'(pair_cnt), 0);
      end else begin
         checks++;
         errors++;
         $display("FAIL wrap_timeout: pair_cnt %0d never wrapped", pair_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
